// File: rtl/asm_seq_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : asm_seq_controller_if
//  Description : Handshake/status bundle between the board-level stimulus and
//                the asm_seq_controller sequencer.
//                  en, a, b      - step enable, start and fire conditions
//                  state         - current FSM state (00 IDLE, 01 ARMED, 10 FIRE)
//                  y             - one-cycle pulse on entry to FIRE
//                  done          - one-cycle pulse when FIRE completes
//                  timeout       - one-cycle pulse when ARMED gives up
//                  err           - sticky illegal-state flag
//                  fire_count    - saturating count of completed FIRE phases
//                master : drives en/a/b, observes status
//                slave  : the sequencer itself
//  Revision    : 1.0  initial release
// ============================================================================
interface asm_seq_controller_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             a;
  logic             b;
  logic [1:0]       state;
  logic             y;
  logic             done;
  logic             timeout;
  logic             err;
  logic [CNT_W-1:0] fire_count;

  modport master (
    output en, a, b,
    input  state, y, done, timeout, err, fire_count
  );

  modport slave (
    input  en, a, b,
    output state, y, done, timeout, err, fire_count
  );
endinterface
`default_nettype wire

// File: rtl/asm_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : asm_seq_controller
//  Description : Registered IDLE -> ARMED -> FIRE -> IDLE sequencer. 'a' is
//                sampled only in IDLE, 'b' only in ARMED. ARMED gives up after
//                TIMEOUT cycles without 'b'; FIRE dwells HOLD_CYCLES enabled
//                cycles. All outputs are registered.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                s    - asm_seq_controller_if.slave (en, a, b in;
//                       state, y, done, timeout, err, fire_count out)
//  Revision    : 1.0  initial release
// ============================================================================
package asm_seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_FIRE    = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;
endpackage

module asm_seq_controller #(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  asm_seq_controller_if.slave  s
);
  import asm_seq_pkg::*;

  localparam int WAIT_W = (TIMEOUT > 1)     ? $clog2(TIMEOUT)     : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            r_state,   w_state_nxt;
  logic [WAIT_W-1:0] r_wait,    w_wait_nxt;
  logic [HOLD_W-1:0] r_hold,    w_hold_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic              r_y,       w_y_nxt;
  logic              r_done,    w_done_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              r_err,     w_err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_y       <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_hold    <= w_hold_nxt;
      r_cnt     <= w_cnt_nxt;
      r_y       <= w_y_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Inputs are only looked at inside the state that samples them, so an X on
  // the other input never reaches a register.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait;
    w_hold_nxt    = r_hold;
    w_cnt_nxt     = r_cnt;
    w_y_nxt       = 1'b0;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_err_nxt     = r_err;

    // Recovery from the unused encoding ignores en.
    if (r_state == S_ILLEGAL) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
    end else if (s.en) begin
      case (r_state)
        S_IDLE: begin
          if (s.a) begin
            w_state_nxt = S_ARMED;
            w_wait_nxt  = '0;
          end
        end
        S_ARMED: begin
          // b takes priority over an expiring wait counter.
          if (s.b) begin
            w_state_nxt = S_FIRE;
            w_y_nxt     = 1'b1;
            w_hold_nxt  = '0;
          end else if (r_wait == C_WAIT_LAST) begin
            w_state_nxt   = S_IDLE;
            w_timeout_nxt = 1'b1;
          end else begin
            w_wait_nxt = r_wait + WAIT_W'(1);
          end
        end
        S_FIRE: begin
          if (r_hold == C_HOLD_LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            if (r_cnt != {CNT_W{1'b1}}) begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign s.state      = r_state;
  assign s.y          = r_y;
  assign s.done       = r_done;
  assign s.timeout    = r_timeout;
  assign s.err        = r_err;
  assign s.fire_count = r_cnt;

endmodule
`default_nettype wire
